// File: rtl/mat_pkg.sv
// Shared matrix types and constants for the row-server and the engines that
// talk to it (lu, triang_matrix_inv, complex_matrix_mul).
//   SIZE   : matrix dimension (rows = cols), power of 2
//   WIDTH  : bits per real/imag part (IEEE double)
//   elem_t : one complex element, real in low WIDTH bits, imag in high WIDTH bits
//   row_t  : SIZE elements, element j at [j*2*WIDTH +: 2*WIDTH]
//   mat_t  : SIZE rows
package mat_pkg;
    localparam int unsigned SIZE  = 4;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned AW    = $clog2(SIZE);

    typedef logic [2*WIDTH-1:0]            elem_t;
    typedef logic [SIZE-1:0][2*WIDTH-1:0]  row_t;
    typedef logic [AW-1:0]                 addr_t;
    typedef row_t [SIZE-1:0]               mat_t;

    // Which source lands in the matrix this cycle.
    typedef enum logic [1:0] {
        WR_NONE   = 2'd0,
        WR_ENGINE = 2'd1,
        WR_HOST   = 2'd2
    } wr_src_t;
endpackage

// File: rtl/mat_row_server_if.sv
// Bus bundle between the row server and its clients (engine + host).
// Signal names keep the engine-facing port naming of the original block.
//   slave  : the row server (responder)
//   master : engine/host side (requester)
interface mat_row_server_if;
    import mat_pkg::*;

    // engine read
    addr_t rd_addr_i;
    logic  rd_addr_valid_i;
    row_t  rd_row_o;
    addr_t rd_addr_o;
    logic  rd_valid_o;
    logic  rd_err_o;
    // engine writeback
    row_t  wr_row_i;
    addr_t wr_addr_i;
    logic  wr_valid_i;
    logic  wr_ready_o;
    // host load
    row_t  host_wr_row_i;
    addr_t host_wr_addr_i;
    logic  host_wr_valid_i;
    logic  host_wr_ready_o;
    // host read
    addr_t host_rd_addr_i;
    logic  host_rd_trans_i;
    logic  host_rd_valid_i;
    row_t  host_rd_row_o;
    logic  host_rd_valid_o;
    // bitmap control / status
    logic  clear_i;
    logic  loaded_o;

    modport slave (
        input  rd_addr_i, rd_addr_valid_i,
        output rd_row_o, rd_addr_o, rd_valid_o, rd_err_o,
        input  wr_row_i, wr_addr_i, wr_valid_i,
        output wr_ready_o,
        input  host_wr_row_i, host_wr_addr_i, host_wr_valid_i,
        output host_wr_ready_o,
        input  host_rd_addr_i, host_rd_trans_i, host_rd_valid_i,
        output host_rd_row_o, host_rd_valid_o,
        input  clear_i,
        output loaded_o
    );

    modport master (
        output rd_addr_i, rd_addr_valid_i,
        input  rd_row_o, rd_addr_o, rd_valid_o, rd_err_o,
        output wr_row_i, wr_addr_i, wr_valid_i,
        input  wr_ready_o,
        output host_wr_row_i, host_wr_addr_i, host_wr_valid_i,
        input  host_wr_ready_o,
        output host_rd_addr_i, host_rd_trans_i, host_rd_valid_i,
        input  host_rd_row_o, host_rd_valid_o,
        output clear_i,
        input  loaded_o
    );
endinterface

// File: rtl/mat_col_gather.sv
// Combinational column extraction: row[j] = mat[j][col].
//   mat : full matrix
//   col : column index
//   row : column packed as a row
module mat_col_gather
    import mat_pkg::*;
(
    input  mat_t  mat,
    input  addr_t col,
    output row_t  row
);
    always_comb begin
        row = '0;
        for (int unsigned j = 0; j < SIZE; j++) begin
            row[j] = mat[j][col];
        end
    end
endmodule

// File: rtl/mat_row_server.sv
// Row-fetch/row-writeback responder holding one SIZE x SIZE complex matrix.
// Engine read and host read each answer one cycle after the request, with
// read-before-write on same-row collisions. Engine writes beat host writes.
//   clk_i : clock
//   rst_i : synchronous reset, active-high (matrix contents are kept)
//   bus   : engine/host bundle, slave side
module mat_row_server
    import mat_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    mat_row_server_if.slave   bus
);
    mat_t           mat;
    logic [SIZE-1:0] written;
    logic [SIZE-1:0] written_nxt;
    wr_src_t        wr_src;
    row_t           col_row;

    assign bus.wr_ready_o      = !rst_i;
    assign bus.host_wr_ready_o = !rst_i && !bus.wr_valid_i;

    always_comb begin
        wr_src = WR_NONE;
        if (!rst_i) begin
            if (bus.wr_valid_i) begin
                wr_src = WR_ENGINE;
            end else if (bus.host_wr_valid_i) begin
                wr_src = WR_HOST;
            end
        end
    end

    // Clear first, then the landing write sets its bit, so a write in the
    // clear cycle survives.
    always_comb begin
        written_nxt = bus.clear_i ? '0 : written;
        case (wr_src)
            WR_ENGINE: written_nxt[bus.wr_addr_i]      = 1'b1;
            WR_HOST:   written_nxt[bus.host_wr_addr_i] = 1'b1;
            default:   ;
        endcase
    end

    // Storage is not reset.
    always_ff @(posedge clk_i) begin
        case (wr_src)
            WR_ENGINE: mat[bus.wr_addr_i]      <= bus.wr_row_i;
            WR_HOST:   mat[bus.host_wr_addr_i] <= bus.host_wr_row_i;
            default:   ;
        endcase
    end

    mat_col_gather u_col_gather (
        .mat (mat),
        .col (bus.host_rd_addr_i),
        .row (col_row)
    );

    // Reads sample mat before this edge's write lands: read-before-write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            written             <= '0;
            bus.loaded_o        <= 1'b0;
            bus.rd_valid_o      <= 1'b0;
            bus.rd_addr_o       <= '0;
            bus.rd_row_o        <= '0;
            bus.rd_err_o        <= 1'b0;
            bus.host_rd_valid_o <= 1'b0;
            bus.host_rd_row_o   <= '0;
        end else begin
            written             <= written_nxt;
            bus.loaded_o        <= &written_nxt;
            bus.rd_valid_o      <= bus.rd_addr_valid_i;
            bus.rd_addr_o       <= bus.rd_addr_i;
            bus.rd_row_o        <= mat[bus.rd_addr_i];
            bus.rd_err_o        <= bus.rd_addr_valid_i && !written[bus.rd_addr_i];
            bus.host_rd_valid_o <= bus.host_rd_valid_i;
            bus.host_rd_row_o   <= bus.host_rd_trans_i ? col_row : mat[bus.host_rd_addr_i];
        end
    end
endmodule
